// File: rtl/pio_input_filtered_irq.sv
// Avalon-MM input PIO for switches and push buttons: per-bit synchroniser,
// optional debounce filter, configurable edge capture with write-1-to-clear,
// per-bit interrupt mask and a registered level interrupt.
module pio_input_filtered_irq #(
  parameter int               WIDTH        = 4,
  parameter int               SYNC_STAGES  = 2,
  parameter int               DEBOUNCE_CYC = 0,
  parameter int               EDGE_TYPE    = 0,
  parameter logic [WIDTH-1:0] RESET_VALUE  = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  // Counter needs to hold 0..DEBOUNCE_CYC; keep at least one bit so the
  // bypass configuration still elaborates cleanly.
  localparam int CNT_W = (DEBOUNCE_CYC < 1) ? 1 : $clog2(DEBOUNCE_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((DEBOUNCE_CYC > 0) ? DEBOUNCE_CYC - 1 : 0);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q, sync_d;
  logic [WIDTH-1:0][CNT_W-1:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0]                  filt_q, filt_d;
  logic [WIDTH-1:0]                  filt_prev_q, filt_prev_d;
  logic [WIDTH-1:0]                  edge_cap_q, edge_cap_d;
  logic [WIDTH-1:0]                  irq_mask_q, irq_mask_d;
  logic [31:0]                       readdata_q, readdata_d;
  logic                              irq_q, irq_d;
  logic [WIDTH-1:0]                  syn;
  logic [WIDTH-1:0]                  edge_det;
  logic                              wr_strobe;

  assign syn       = sync_q[SYNC_STAGES-1];
  assign wr_strobe = chipselect & ~write_n;

  // Synchroniser shift chain: stage 0 samples the raw pins.
  always_comb begin
    sync_d    = sync_q;
    sync_d[0] = in_port;
    for (int s = 1; s < SYNC_STAGES; s++) begin
      sync_d[s] = sync_q[s-1];
    end
  end

  // Debounce: a bit follows the synchronised input only after it has
  // disagreed for DEBOUNCE_CYC consecutive cycles; bypassed when zero.
  always_comb begin
    filt_d = filt_q;
    cnt_d  = cnt_q;
    if (DEBOUNCE_CYC == 0) begin
      filt_d = syn;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (syn[i] == filt_q[i]) begin
          cnt_d[i] = '0;
        end else if (cnt_q[i] == CNT_LAST) begin
          filt_d[i] = syn[i];
          cnt_d[i]  = '0;
        end else if (cnt_q[i] != CNT_MAX) begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  // Edge detection on the filtered value against its one-cycle history.
  always_comb begin
    filt_prev_d = filt_q;
    case (EDGE_TYPE)
      1:       edge_det = ~filt_q & filt_prev_q;
      2:       edge_det = filt_q ^ filt_prev_q;
      default: edge_det = filt_q & ~filt_prev_q;
    endcase
  end

  // Register file: mask write, W1C on captures (a new edge beats the clear),
  // registered read mux and registered interrupt.
  always_comb begin
    irq_mask_d = irq_mask_q;
    edge_cap_d = edge_cap_q;
    if (wr_strobe && (address == 2'd2)) begin
      irq_mask_d = writedata[WIDTH-1:0];
    end
    if (wr_strobe && (address == 2'd3)) begin
      edge_cap_d = edge_cap_q & ~writedata[WIDTH-1:0];
    end
    edge_cap_d = edge_cap_d | edge_det;

    readdata_d = '0;
    case (address)
      2'd0:    readdata_d[WIDTH-1:0] = filt_q;
      2'd2:    readdata_d[WIDTH-1:0] = irq_mask_q;
      2'd3:    readdata_d[WIDTH-1:0] = edge_cap_q;
      default: readdata_d = '0;
    endcase

    irq_d = |(edge_cap_q & irq_mask_q);
  end

  // State registers; input-path flops reset to RESET_VALUE so no edge is
  // seen out of reset when the pins already sit at that value.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q      <= {SYNC_STAGES{RESET_VALUE}};
      filt_q      <= RESET_VALUE;
      filt_prev_q <= RESET_VALUE;
      cnt_q       <= '0;
      edge_cap_q  <= '0;
      irq_mask_q  <= '0;
      readdata_q  <= '0;
      irq_q       <= 1'b0;
    end else begin
      sync_q      <= sync_d;
      filt_q      <= filt_d;
      filt_prev_q <= filt_prev_d;
      cnt_q       <= cnt_d;
      edge_cap_q  <= edge_cap_d;
      irq_mask_q  <= irq_mask_d;
      readdata_q  <= readdata_d;
      irq_q       <= irq_d;
    end
  end

  assign readdata = readdata_q;
  assign irq      = irq_q;

  generate
    if (WIDTH < 32) begin : g_unused_wdata
      logic unused_wdata_bits;
      assign unused_wdata_bits = ^writedata[31:WIDTH];
    end
  endgenerate

endmodule

// File: tb/tb_pio_input_filtered_irq.sv
// Bench for pio_input_filtered_irq: three configurations share one bus and
// are compared every cycle against a behavioural model, with directed
// scenarios followed by a randomised phase.
module tb_pio_input_filtered_irq;

  logic        clk;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [3:0]  in_a, in_b, in_c;
  logic [31:0] rd_a, rd_b, rd_c;
  logic        irq_a, irq_b, irq_c;

  int n_cmp = 0;
  int n_bad = 0;

  // A: defaults (rising, no debounce). B: debounce 8, any edge.
  // C: 3-stage sync, debounce 3, falling edge, reset value all ones.
  pio_input_filtered_irq u_a (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(rd_a), .in_port(in_a), .irq(irq_a));

  pio_input_filtered_irq #(.WIDTH(4), .SYNC_STAGES(2), .DEBOUNCE_CYC(8), .EDGE_TYPE(2),
                           .RESET_VALUE(4'h0)) u_b (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(rd_b), .in_port(in_b), .irq(irq_b));

  pio_input_filtered_irq #(.WIDTH(4), .SYNC_STAGES(3), .DEBOUNCE_CYC(3), .EDGE_TYPE(1),
                           .RESET_VALUE(4'hF)) u_c (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(rd_c), .in_port(in_c), .irq(irq_c));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  function automatic int p_s(int k);
    return (k == 2) ? 3 : 2;
  endfunction
  function automatic int p_d(int k);
    return (k == 0) ? 0 : ((k == 1) ? 8 : 3);
  endfunction
  function automatic int p_e(int k);
    return (k == 0) ? 0 : ((k == 1) ? 2 : 1);
  endfunction
  function automatic logic [3:0] p_rv(int k);
    return (k == 2) ? 4'hF : 4'h0;
  endfunction

  logic [3:0]  m_hist [3][4];   // input history, [0] = most recent sample
  int          m_run  [3][4];   // consecutive cycles synced input disagreed with filtered
  logic [3:0]  m_filt [3];
  logic [3:0]  m_prev [3];
  logic [3:0]  m_cap  [3];
  logic [3:0]  m_mask [3];
  logic        m_irq  [3];
  logic [31:0] m_rd   [3];

  function automatic logic [3:0] get_in(int k);
    return (k == 0) ? in_a : ((k == 1) ? in_b : in_c);
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      for (int j = 0; j < 4; j++) begin
        m_hist[k][j] = p_rv(k);
        m_run[k][j]  = 0;
      end
      m_filt[k] = p_rv(k);
      m_prev[k] = p_rv(k);
      m_cap[k]  = 4'h0;
      m_mask[k] = 4'h0;
      m_irq[k]  = 1'b0;
      m_rd[k]   = 32'h0;
    end
  endtask

  task automatic model_clock();
    logic wr;
    wr = chipselect && !write_n;
    for (int k = 0; k < 3; k++) begin
      logic [3:0]  syn, nfilt, edges, ncap;
      logic [31:0] nrd;
      syn   = m_hist[k][p_s(k)-1];
      nfilt = m_filt[k];
      for (int b = 0; b < 4; b++) begin
        if (p_d(k) == 0) begin
          nfilt[b] = syn[b];
        end else if (syn[b] == m_filt[k][b]) begin
          m_run[k][b] = 0;
        end else begin
          m_run[k][b]++;
          if (m_run[k][b] >= p_d(k)) begin
            nfilt[b]    = syn[b];
            m_run[k][b] = 0;
          end
        end
      end
      if (p_e(k) == 0)      edges = m_filt[k] & ~m_prev[k];
      else if (p_e(k) == 1) edges = ~m_filt[k] & m_prev[k];
      else                  edges = m_filt[k] ^ m_prev[k];
      ncap = m_cap[k];
      if (wr && address == 2'd3) ncap = ncap & ~writedata[3:0];
      ncap = ncap | edges;
      nrd = 32'h0;
      if (address == 2'd0)      nrd[3:0] = m_filt[k];
      else if (address == 2'd2) nrd[3:0] = m_mask[k];
      else if (address == 2'd3) nrd[3:0] = m_cap[k];
      m_irq[k] = |(m_cap[k] & m_mask[k]);
      if (wr && address == 2'd2) m_mask[k] = writedata[3:0];
      m_cap[k]  = ncap;
      m_rd[k]   = nrd;
      m_prev[k] = m_filt[k];
      m_filt[k] = nfilt;
      for (int j = 3; j > 0; j--) m_hist[k][j] = m_hist[k][j-1];
      m_hist[k][0] = get_in(k);
    end
  endtask

  // ---------------- checking helpers ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("a_readdata", rd_a, m_rd[0]);
    chk("a_irq", {31'b0, irq_a}, {31'b0, m_irq[0]});
    chk("b_readdata", rd_b, m_rd[1]);
    chk("b_irq", {31'b0, irq_b}, {31'b0, m_irq[1]});
    chk("c_readdata", rd_c, m_rd[2]);
    chk("c_irq", {31'b0, irq_c}, {31'b0, m_irq[2]});
  endtask

  task automatic step();
    @(posedge clk);
    if (reset_n) model_clock();
    #1;
    check_all();
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    step();
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  // ---------------- directed + random stimulus ----------------
  initial begin
    reset_n    = 1'b0;
    address    = 2'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = 32'h0;
    in_a       = 4'h0;
    in_b       = 4'h0;
    in_c       = 4'hF;
    model_reset();
    steps(3);
    chk("reset_rd_a", rd_a, 32'h0);
    chk("reset_irq_a", {31'b0, irq_a}, 32'h0);
    reset_n = 1'b1;

    // Defaults: 0000 -> 0101 captured after 4 clocks, visible one read later.
    address = 2'd3;
    in_a    = 4'b0101;
    steps(5);
    chk("t1_capture", rd_a, 32'h5);
    address = 2'd0;
    step();
    chk("t1_data", rd_a, 32'h5);

    // Debounce 8: a 5-cycle pulse is filtered out, an 8+ cycle hold is not.
    in_b = 4'b0100;
    steps(5);
    in_b = 4'b0000;
    steps(20);
    chk("t2_glitch_filt", rd_b, 32'h0);
    address = 2'd3;
    step();
    chk("t2_glitch_cap", rd_b, 32'h0);
    address = 2'd0;
    in_b    = 4'b0100;
    steps(14);
    chk("t2_hold_filt", rd_b, 32'h4);
    address = 2'd3;
    step();
    chk("t2_hold_cap", rd_b, 32'h4);

    // Any-edge capture with W1C between toggles.
    bus_write(2'd3, 32'hF);
    in_b = 4'b0101;
    steps(14);
    chk("t3_rise_cap", rd_b, 32'h1);
    bus_write(2'd3, 32'h0);
    step();
    chk("t3_w1c_zero", rd_b, 32'h1);
    bus_write(2'd3, 32'h1);
    step();
    chk("t3_w1c_one", rd_b, 32'h0);
    in_b = 4'b0100;
    steps(14);
    chk("t3_fall_cap", rd_b, 32'h1);
    bus_write(2'd3, 32'hF);

    // Mask 0x2: bit3 edge stays quiet, bit1 edge raises irq, W1C drops it.
    bus_write(2'd2, 32'h2);
    bus_write(2'd3, 32'hF);
    in_a = 4'b1101;
    steps(8);
    chk("t4_bit3_irq", {31'b0, irq_a}, 32'h0);
    chk("t4_bit3_cap", rd_a, 32'h8);
    in_a = 4'b1111;
    steps(8);
    chk("t4_bit1_irq", {31'b0, irq_a}, 32'h1);
    bus_write(2'd3, 32'h2);
    step();
    chk("t4_clear_irq", {31'b0, irq_a}, 32'h0);

    // W1C landing in the same cycle as a new bit1 capture: edge wins.
    in_a = 4'b1101;
    steps(8);
    bus_write(2'd3, 32'hF);
    in_a = 4'b1111;
    steps(3);
    bus_write(2'd3, 32'h2);
    step();
    chk("t5_edge_wins", rd_a & 32'h2, 32'h2);

    // Reset while captures, mask and a debounce are all in flight.
    bus_write(2'd2, 32'hF);
    in_b = 4'b0110;
    in_c = 4'b1110;
    steps(12);
    in_b = 4'b0111;
    steps(4);
    chk("t6_pre_irq_b", {31'b0, irq_b}, 32'h1);
    reset_n = 1'b0;
    model_reset();
    #1;
    check_all();
    chk("t6_irq_b_now", {31'b0, irq_b}, 32'h0);
    chk("t6_rd_c_now", rd_c, 32'h0);
    in_a = 4'h0;
    in_b = 4'h0;
    in_c = 4'hF;
    #2;
    reset_n = 1'b1;
    address = 2'd3;
    steps(30);
    chk("t6_no_edge_a", rd_a, 32'h0);
    chk("t6_no_edge_b", rd_b, 32'h0);
    chk("t6_no_edge_c", rd_c, 32'h0);
    address = 2'd2;
    step();
    chk("t6_mask_lost", rd_b, 32'h0);

    // Randomised phase: inputs hold for random spans, random bus traffic.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 9) == 0) in_a = 4'($urandom());
      if ($urandom_range(0, 5) == 0) in_b = 4'($urandom());
      if ($urandom_range(0, 4) == 0) in_c = 4'($urandom());
      address    = 2'($urandom());
      writedata  = $urandom();
      chipselect = ($urandom_range(0, 3) != 0);
      write_n    = ($urandom_range(0, 2) != 0);
      step();
    end
    chipselect = 1'b0;
    write_n    = 1'b1;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
